// File: rtl/regfile_wb_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : regfile_wb_arbiter_if
// Description : Bus bundle between two write-back requesters (ALU = req0,
//               load unit = req1), the register-file write port and the
//               write-back arbiter.
//               slave  : arbiter view (takes requests, drives grants/write)
//               master : requester/regfile view (drives requests and hold)
//               Signals:
//                 hold                   - regfile write port busy
//                 reqN_valid/rd/data     - write request N
//                 reqN_ready             - request N accepted this cycle
//                 wr_en/wr_addr/wr_data  - registered regfile write port
//                 wr_valid               - write stage occupied / bypass valid
//                 conflict_cnt           - saturating contention counter
// Revision    : 1.0 - initial release
// ============================================================================
interface regfile_wb_arbiter_if #(
    parameter int bits            = 32,
    parameter int no_of_registers = 32
);
    localparam int c_AW = $clog2(no_of_registers);

    logic                       hold;
    logic                       req0_valid;
    logic [c_AW-1:0]            req0_rd;
    logic [bits-1:0]            req0_data;
    logic                       req0_ready;
    logic                       req1_valid;
    logic [c_AW-1:0]            req1_rd;
    logic [bits-1:0]            req1_data;
    logic                       req1_ready;
    logic [no_of_registers-1:0] wr_en;
    logic [c_AW-1:0]            wr_addr;
    logic [bits-1:0]            wr_data;
    logic                       wr_valid;
    logic [7:0]                 conflict_cnt;

    modport slave (
        input  hold,
        input  req0_valid, req0_rd, req0_data,
        output req0_ready,
        input  req1_valid, req1_rd, req1_data,
        output req1_ready,
        output wr_en, wr_addr, wr_data, wr_valid, conflict_cnt
    );

    modport master (
        output hold,
        output req0_valid, req0_rd, req0_data,
        input  req0_ready,
        output req1_valid, req1_rd, req1_data,
        input  req1_ready,
        input  wr_en, wr_addr, wr_data, wr_valid, conflict_cnt
    );
endinterface
`default_nettype wire

// File: rtl/regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : regfile_wb_arbiter
// Description : Two-requester write-back arbiter in front of a register-file
//               write port. Grants are combinational from the current valids,
//               hold and a round-robin priority bit; an accepted request is
//               registered into a single write stage one cycle later.
//               Ports:
//                 clk          - clock, all state on rising edge
//                 async_reset  - asynchronous active-low reset
//                 bus          - regfile_wb_arbiter_if.slave bundle
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_wb_arbiter #(
    parameter int bits            = 32,
    parameter int no_of_registers = 32
) (
    input  logic                   clk,
    input  logic                   async_reset,
    regfile_wb_arbiter_if.slave    bus
);
    localparam int                         c_AW      = $clog2(no_of_registers);
    localparam logic [7:0]                 c_CNT_MAX = 8'hFF;
    localparam logic [no_of_registers-1:0] c_ONE     = no_of_registers'(1);

    logic                       r_prio;       // 0: req0 wins a tie, 1: req1 wins
    logic                       r_wr_valid;
    logic [c_AW-1:0]            r_wr_addr;
    logic [bits-1:0]            r_wr_data;
    logic [7:0]                 r_conflict_cnt;

    logic                       w_ready0;
    logic                       w_ready1;
    logic                       w_contend;
    logic [no_of_registers-1:0] w_wr_en;

    // Grants depend only on inputs and r_prio, never on the write stage.
    // Gating with async_reset keeps both grants low while reset is held.
    assign w_contend = bus.req0_valid & bus.req1_valid & ~bus.hold;
    assign w_ready0  = async_reset & ~bus.hold & bus.req0_valid
                     & (~bus.req1_valid | ~r_prio);
    assign w_ready1  = async_reset & ~bus.hold & bus.req1_valid
                     & (~bus.req0_valid | r_prio);

    // Register x0 is hard-wired, so a write to it never raises an enable.
    assign w_wr_en = (r_wr_valid && (r_wr_addr != '0)) ? (c_ONE << r_wr_addr)
                                                       : '0;

    always_ff @(posedge clk or negedge async_reset) begin
        if (!async_reset) begin
            r_prio         <= 1'b0;
            r_wr_valid     <= 1'b0;
            r_wr_addr      <= '0;
            r_wr_data      <= '0;
            r_conflict_cnt <= '0;
        end else begin
            if (w_ready0) begin
                r_wr_valid <= 1'b1;
                r_wr_addr  <= bus.req0_rd;
                r_wr_data  <= bus.req0_data;
                r_prio     <= 1'b1;
            end else if (w_ready1) begin
                r_wr_valid <= 1'b1;
                r_wr_addr  <= bus.req1_rd;
                r_wr_data  <= bus.req1_data;
                r_prio     <= 1'b0;
            end else begin
                // Address and data keep their last value; only valid drops.
                r_wr_valid <= 1'b0;
            end

            if (w_contend && (r_conflict_cnt != c_CNT_MAX)) begin
                r_conflict_cnt <= r_conflict_cnt + 8'd1;
            end
        end
    end

    assign bus.req0_ready   = w_ready0;
    assign bus.req1_ready   = w_ready1;
    assign bus.wr_en        = w_wr_en;
    assign bus.wr_addr      = r_wr_addr;
    assign bus.wr_data      = r_wr_data;
    assign bus.wr_valid     = r_wr_valid;
    assign bus.conflict_cnt = r_conflict_cnt;
endmodule
`default_nettype wire

// File: tb/tb_regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile_wb_arbiter
// Description : Directed self-checking bench for regfile_wb_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_wb_arbiter;
    logic clk;
    logic async_reset;
    int   n_total;
    int   n_bad;

    regfile_wb_arbiter_if #(.bits(32), .no_of_registers(32)) bus ();

    regfile_wb_arbiter #(.bits(32), .no_of_registers(32)) dut (
        .clk         (clk),
        .async_reset (async_reset),
        .bus         (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_total = 0;
        n_bad   = 0;
        async_reset    = 1'b0;
        bus.hold       = 1'b0;
        bus.req0_valid = 1'b1;
        bus.req0_rd    = 5'd5;
        bus.req0_data  = 32'hDEADBEEF;
        bus.req1_valid = 1'b0;
        bus.req1_rd    = 5'd0;
        bus.req1_data  = 32'h0;

        // Reset state, with a request pending that must not be granted.
        #2;
        chk("rst_wr_valid", 64'(bus.wr_valid), 64'd0);
        chk("rst_wr_en", 64'(bus.wr_en), 64'd0);
        chk("rst_wr_addr", 64'(bus.wr_addr), 64'd0);
        chk("rst_wr_data", 64'(bus.wr_data), 64'd0);
        chk("rst_cnt", 64'(bus.conflict_cnt), 64'd0);
        chk("rst_ready0", 64'(bus.req0_ready), 64'd0);
        repeat (2) @(posedge clk);
        #3 async_reset = 1'b1;

        // Single request, accepted on first edge after release.
        #1;
        chk("single_ready0", 64'(bus.req0_ready), 64'd1);
        chk("single_ready1", 64'(bus.req1_ready), 64'd0);
        tick;
        bus.req0_valid = 1'b0;
        chk("single_wr_valid", 64'(bus.wr_valid), 64'd1);
        chk("single_wr_en", 64'(bus.wr_en), 64'h20);
        chk("single_wr_addr", 64'(bus.wr_addr), 64'd5);
        chk("single_wr_data", 64'(bus.wr_data), 64'hDEADBEEF);

        // x0 write from req1.
        bus.req1_valid = 1'b1;
        bus.req1_rd    = 5'd0;
        bus.req1_data  = 32'h1234;
        #1;
        chk("x0_ready1", 64'(bus.req1_ready), 64'd1);
        chk("x0_ready0", 64'(bus.req0_ready), 64'd0);
        tick;
        bus.req1_valid = 1'b0;
        chk("x0_wr_valid", 64'(bus.wr_valid), 64'd1);
        chk("x0_wr_en", 64'(bus.wr_en), 64'd0);

        // Idle cycle: valid drops, data holds.
        tick;
        chk("idle_wr_valid", 64'(bus.wr_valid), 64'd0);
        chk("idle_wr_en", 64'(bus.wr_en), 64'd0);
        chk("idle_wr_data", 64'(bus.wr_data), 64'h1234);

        // Contention: grants alternate starting with req0 (prio back at 0).
        bus.req0_valid = 1'b1;
        bus.req0_rd    = 5'd3;
        bus.req0_data  = 32'hAAAA0003;
        bus.req1_valid = 1'b1;
        bus.req1_rd    = 5'd7;
        bus.req1_data  = 32'hBBBB0007;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("alt_ready0", 64'(bus.req0_ready), (i % 2 == 0) ? 64'd1 : 64'd0);
            chk("alt_ready1", 64'(bus.req1_ready), (i % 2 == 0) ? 64'd0 : 64'd1);
            tick;
            chk("alt_wr_en", 64'(bus.wr_en), (i % 2 == 0) ? 64'h8 : 64'h80);
            chk("alt_wr_data", 64'(bus.wr_data),
                (i % 2 == 0) ? 64'hAAAA0003 : 64'hBBBB0007);
        end
        chk("alt_cnt", 64'(bus.conflict_cnt), 64'd4);

        // Hold blocks everything and does not count.
        bus.hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("hold_ready0", 64'(bus.req0_ready), 64'd0);
            chk("hold_ready1", 64'(bus.req1_ready), 64'd0);
            tick;
            chk("hold_wr_valid", 64'(bus.wr_valid), 64'd0);
        end
        chk("hold_cnt", 64'(bus.conflict_cnt), 64'd4);
        bus.hold = 1'b0;
        #1;
        chk("unhold_ready0", 64'(bus.req0_ready), 64'd1);
        chk("unhold_ready1", 64'(bus.req1_ready), 64'd0);
        tick;
        chk("unhold_wr_addr", 64'(bus.wr_addr), 64'd3);
        chk("unhold_cnt", 64'(bus.conflict_cnt), 64'd5);

        // Same destination: req1 (prio now 1) first, then req0.
        bus.req0_rd   = 5'd9;
        bus.req0_data = 32'h111;
        bus.req1_rd   = 5'd9;
        bus.req1_data = 32'h222;
        #1;
        chk("same_ready1", 64'(bus.req1_ready), 64'd1);
        tick;
        bus.req1_valid = 1'b0;
        chk("same_first_data", 64'(bus.wr_data), 64'h222);
        chk("same_cnt", 64'(bus.conflict_cnt), 64'd6);
        #1;
        chk("same_ready0", 64'(bus.req0_ready), 64'd1);
        tick;
        chk("same_second_data", 64'(bus.wr_data), 64'h111);
        chk("same_second_en", 64'(bus.wr_en), 64'h200);
        chk("same_cnt_single", 64'(bus.conflict_cnt), 64'd6);

        // Saturation: 300 contended cycles starting from 6.
        bus.req1_valid = 1'b1;
        repeat (248) tick;
        chk("sat_254", 64'(bus.conflict_cnt), 64'd254);
        repeat (52) tick;
        chk("sat_255", 64'(bus.conflict_cnt), 64'd255);
        chk("pre_rst_wr_valid", 64'(bus.wr_valid), 64'd1);

        // Reset mid-flight, between edges.
        #3 async_reset = 1'b0;
        #1;
        chk("mid_rst_wr_valid", 64'(bus.wr_valid), 64'd0);
        chk("mid_rst_wr_en", 64'(bus.wr_en), 64'd0);
        chk("mid_rst_cnt", 64'(bus.conflict_cnt), 64'd0);
        chk("mid_rst_ready0", 64'(bus.req0_ready), 64'd0);
        chk("mid_rst_ready1", 64'(bus.req1_ready), 64'd0);
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        @(negedge clk);
        async_reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick;
            chk("post_rst_wr_valid", 64'(bus.wr_valid), 64'd0);
        end
        chk("post_rst_wr_data", 64'(bus.wr_data), 64'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
`default_nettype wire
